// File: rtl/pp_gen_gated.sv
// pp_gen_gated: registered partial-product generator with operand-driven
// clock-gate enable, feeding the reduction tree of the approximate multiplier.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   in_valid/ready  - operand pair handshake (a = multiplicand, b = multiplier)
//   a, b            - WIDTH-bit operands
//   pp_valid/ready  - output handshake towards the reduction tree
//   pp              - WIDTH*WIDTH AND matrix, pp[i*WIDTH+j] = a_q[j] & b_q[i]
//   zero_op         - held pair had a zero operand (pp forced to 0)
//   reg_en          - combinational operand-register load / clock-gate enable
//   gate_cnt        - saturating count of accepted pairs that did not load
module pp_gen_gated #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     pp_valid,
  input  logic                     pp_ready,
  output logic [WIDTH*WIDTH-1:0]   pp,
  output logic                     zero_op,
  output logic                     reg_en,
  output logic [15:0]              gate_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             zero_q;
  logic             acc, zero, same;

  assign in_ready = (state == EMPTY) | pp_ready;
  assign acc      = in_valid & in_ready;
  assign zero     = (a == '0) | (b == '0);
  assign same     = (a == a_q) & (b == b_q);
  assign reg_en   = acc & ~zero & ~same;

  assign pp_valid = (state == FULL);
  assign zero_op  = zero_q;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (acc) state_nxt = FULL;
      FULL:    if (pp_ready && !acc) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      a_q      <= '0;
      b_q      <= '0;
      zero_q   <= 1'b1;
      gate_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (reg_en) begin
        a_q <= a;
        b_q <= b;
      end
      if (acc) zero_q <= zero;
      if (acc && !reg_en && gate_cnt != 16'hFFFF) gate_cnt <= gate_cnt + 16'd1;
    end
  end

  // Pure function of the held registers: no path from a/b to pp.
  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        pp[i*WIDTH+j] = a_q[j] & b_q[i] & ~zero_q;
      end
    end
  end

endmodule

// File: tb/tb_pp_gen_gated.sv
// Self-checking bench for pp_gen_gated at WIDTH=4: directed steps with a
// scoreboard queue of expected {zero_op, pp} drained by a negedge monitor.
module tb_pp_gen_gated;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          pp_valid;
  logic          pp_ready;
  logic [W*W-1:0] pp;
  logic          zero_op;
  logic          reg_en;
  logic [15:0]   gate_cnt;

  int checks = 0;
  int errors = 0;

  logic [16:0] sb[$];
  logic [W-1:0] ma, mb;
  logic [15:0]  mg;
  logic [16:0]  hold_exp;

  pp_gen_gated #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .pp_valid(pp_valid), .pp_ready(pp_ready), .pp(pp),
    .zero_op(zero_op), .reg_en(reg_en), .gate_cnt(gate_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Row i of the matrix is the multiplicand when multiplier bit i is set.
  function automatic logic [W*W-1:0] mk(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) if (y[i]) r[i*W +: W] = x;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && pp_valid && pp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("pp", {16'd0, pp}, {16'd0, e[15:0]});
        chk("zero_op", {31'd0, zero_op}, {31'd0, e[16]});
      end
    end
  end

  // One accepted pair with pp_ready=1; model updated in the drive cycle.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit quiet);
    logic z, s, en;
    in_valid = 1'b1; a = x; b = y; pp_ready = 1'b1;
    z  = (x == 0) || (y == 0);
    s  = (x == ma) && (y == mb);
    en = !z && !s;
    if (en) begin ma = x; mb = y; end
    sb.push_back({z, z ? 16'h0000 : mk(ma, mb)});
    @(negedge clk);
    if (!quiet) begin
      chk("reg_en", {31'd0, reg_en}, {31'd0, en});
      chk("in_ready", {31'd0, in_ready}, 32'd1);
      chk("gate_cnt", {16'd0, gate_cnt}, {16'd0, mg});
    end
    if (!en && mg != 16'hFFFF) mg++;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; pp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pp_ready = 1'b1; a = '0; b = '0;
    ma = '0; mb = '0; mg = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pp_valid", {31'd0, pp_valid}, 32'd0);
    chk("rst_pp", {16'd0, pp}, 32'd0);
    chk("rst_zero_op", {31'd0, zero_op}, 32'd1);
    chk("rst_gate_cnt", {16'd0, gate_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_reg_en", {31'd0, reg_en}, 32'd0);
    @(posedge clk); #1;

    // Basic product
    send(4'hB, 4'h5, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("basic_pp_value", {16'd0, pp}, 32'h0B0B);
    chk("basic_pp_valid", {31'd0, pp_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("basic_drained", {31'd0, pp_valid}, 32'd0);
    @(posedge clk); #1;

    // Zero gating, then repeat of last nonzero pair is gated as same
    send(4'h7, 4'h0, 0);
    send(4'hB, 4'h5, 0);
    idle();
    @(negedge clk);
    chk("gate_after_zero", {16'd0, gate_cnt}, 32'd2);
    @(posedge clk); #1;

    // Streaming distinct nonzero pairs
    send(4'h1, 4'h2, 0);
    send(4'h3, 4'h4, 0);
    send(4'h5, 4'h6, 0);
    send(4'hF, 4'hF, 0);
    send(4'h9, 4'h3, 0);

    // Backpressure: pp of (9,3) must hold while pp_ready=0
    hold_exp = {1'b0, mk(4'h9, 4'h3)};
    in_valid = 1'b1; a = 4'hC; b = 4'h6; pp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_reg_en", {31'd0, reg_en}, 32'd0);
      chk("bp_pp_valid", {31'd0, pp_valid}, 32'd1);
      chk("bp_pp", {16'd0, pp}, {16'd0, hold_exp[15:0]});
      @(posedge clk); #1;
    end
    send(4'hC, 4'h6, 0);
    in_valid = 1'b0; pp_ready = 1'b0;
    @(negedge clk);
    chk("bp_b2b_valid", {31'd0, pp_valid}, 32'd1);
    chk("bp_b2b_pp", {16'd0, pp}, {16'd0, mk(4'hC, 4'h6)});
    @(posedge clk); #1;
    idle();
    idle();

    // Reset mid-transfer discards held entry and the presented pair
    send(4'h2, 4'h3, 0);
    pp_ready = 1'b0; in_valid = 1'b1; a = 4'h3; b = 4'h3; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    ma = '0; mb = '0; mg = '0;
    @(negedge clk);
    chk("midrst_pp_valid", {31'd0, pp_valid}, 32'd0);
    chk("midrst_pp", {16'd0, pp}, 32'd0);
    chk("midrst_zero_op", {31'd0, zero_op}, 32'd1);
    chk("midrst_gate_cnt", {16'd0, gate_cnt}, 32'd0);
    @(posedge clk); #1;

    // Saturation of the gated-event counter
    for (int n = 0; n < 65540; n++) send(4'h7, 4'h0, 1);
    idle();
    @(negedge clk);
    chk("sat_gate_cnt", {16'd0, gate_cnt}, {16'd0, mg});
    chk("sat_value", {16'd0, gate_cnt}, 32'h0000FFFF);
    chk("sb_drained", sb.size(), 32'd0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
